// File: rtl/tri_bbox_scanner.sv
// Triangle setup and bounding-box traversal: clamps the box to the screen and walks it one pixel per cycle.
// Optional RASTER_WINDING_FIX_EN: signed-area test that swaps v1/v2 for negative winding and drops degenerate triangles.
module tri_bbox_scanner #(
   parameter int FRAC_BITS = 4,
   parameter int SCREEN_W  = 640,
   parameter int SCREEN_H  = 480,
   parameter int COORD_W   = 10
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               tri_valid,
   output logic               tri_ready,
   input  logic [15:0]        v0x,
   input  logic [15:0]        v0y,
   input  logic [15:0]        v1x,
   input  logic [15:0]        v1y,
   input  logic [15:0]        v2x,
   input  logic [15:0]        v2y,
   output logic [15:0]        ef_v0x,
   output logic [15:0]        ef_v0y,
   output logic [15:0]        ef_v1x,
   output logic [15:0]        ef_v1y,
   output logic [15:0]        ef_v2x,
   output logic [15:0]        ef_v2y,
   output logic [15:0]        ef_px,
   output logic [15:0]        ef_py,
   input  logic               ef_inside,
   output logic               frag_valid,
   input  logic               frag_ready,
   output logic [COORD_W-1:0] frag_x,
   output logic [COORD_W-1:0] frag_y,
   output logic               tri_done,
   output logic [1:0]         state_dbg
);

   typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, SCAN = 2'd2} state_t;

   localparam logic signed [15:0] X_LAST = 16'(SCREEN_W - 1);
   localparam logic signed [15:0] Y_LAST = 16'(SCREEN_H - 1);
   localparam logic [15:0]        HALF   = 16'(1 << (FRAC_BITS - 1));
   localparam logic [COORD_W:0]   ONE    = (COORD_W + 1)'(1);

   state_t state_q, state_d;

   logic signed [15:0] v0x_r, v0y_r, v1x_r, v1y_r, v2x_r, v2y_r;
   logic [COORD_W-1:0] xmin_r, xmax_r, ymax_r;
   logic [COORD_W:0]   x_q, y_q;
   logic               empty_done_q;

   logic signed [15:0] bx_lo, bx_hi, by_lo, by_hi;
   logic               offscreen, box_empty, adv, last;

   function automatic logic signed [15:0] min3(input logic signed [15:0] a, b, c);
      logic signed [15:0] m;
      m = (a < b) ? a : b;
      return (c < m) ? c : m;
   endfunction

   function automatic logic signed [15:0] max3(input logic signed [15:0] a, b, c);
      logic signed [15:0] m;
      m = (a > b) ? a : b;
      return (c > m) ? c : m;
   endfunction

   // Floor to whole pixels, then reject boxes that miss the screen entirely.
   assign bx_lo = min3(v0x_r, v1x_r, v2x_r) >>> FRAC_BITS;
   assign bx_hi = max3(v0x_r, v1x_r, v2x_r) >>> FRAC_BITS;
   assign by_lo = min3(v0y_r, v1y_r, v2y_r) >>> FRAC_BITS;
   assign by_hi = max3(v0y_r, v1y_r, v2y_r) >>> FRAC_BITS;

   assign offscreen = (bx_lo > bx_hi) || (by_lo > by_hi) || bx_hi[15] || by_hi[15] ||
                      (bx_lo > X_LAST) || (by_lo > Y_LAST);

`ifdef RASTER_WINDING_FIX_EN
   logic signed [16:0] d10x, d10y, d20x, d20y;
   logic signed [33:0] prod_a, prod_b;
   logic signed [34:0] area;
   logic               swap_r;

   assign d10x   = {v1x_r[15], v1x_r} - {v0x_r[15], v0x_r};
   assign d10y   = {v1y_r[15], v1y_r} - {v0y_r[15], v0y_r};
   assign d20x   = {v2x_r[15], v2x_r} - {v0x_r[15], v0x_r};
   assign d20y   = {v2y_r[15], v2y_r} - {v0y_r[15], v0y_r};
   assign prod_a = d20x * d10y;
   assign prod_b = d20y * d10x;
   assign area   = {prod_a[33], prod_a} - {prod_b[33], prod_b};

   assign box_empty = offscreen || (area == '0);
   assign ef_v1x    = swap_r ? v2x_r : v1x_r;
   assign ef_v1y    = swap_r ? v2y_r : v1y_r;
   assign ef_v2x    = swap_r ? v1x_r : v2x_r;
   assign ef_v2y    = swap_r ? v1y_r : v2y_r;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)              swap_r <= 1'b0;
      else if (state_q == SETUP) swap_r <= area[34];
   end
`else
   assign box_empty = offscreen;
   assign ef_v1x    = v1x_r;
   assign ef_v1y    = v1y_r;
   assign ef_v2x    = v2x_r;
   assign ef_v2y    = v2y_r;
`endif

   assign ef_v0x = v0x_r;
   assign ef_v0y = v0y_r;

   // A held fragment blocks sampling; the consumer must take it first.
   assign adv  = (state_q == SCAN) && (!frag_valid || frag_ready);
   assign last = (x_q == {1'b0, xmax_r}) && (y_q == {1'b0, ymax_r});

   assign ef_px = (state_q == SCAN) ? ((16'(x_q) << FRAC_BITS) + HALF) : '0;
   assign ef_py = (state_q == SCAN) ? ((16'(y_q) << FRAC_BITS) + HALF) : '0;

   assign tri_ready = rst_n && (state_q == IDLE) && !empty_done_q;
   assign tri_done  = empty_done_q || (adv && last);
   assign state_dbg = state_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (tri_valid && tri_ready) state_d = SETUP;
         SETUP:   state_d = box_empty ? IDLE : SCAN;
         SCAN:    if (adv && last) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v0x_r <= '0; v0y_r <= '0; v1x_r <= '0; v1y_r <= '0; v2x_r <= '0; v2y_r <= '0;
         xmin_r       <= '0;
         xmax_r       <= '0;
         ymax_r       <= '0;
         x_q          <= '0;
         y_q          <= '0;
         empty_done_q <= 1'b0;
         frag_valid   <= 1'b0;
         frag_x       <= '0;
         frag_y       <= '0;
      end else begin
         if (tri_valid && tri_ready) begin
            v0x_r <= v0x; v0y_r <= v0y; v1x_r <= v1x; v1y_r <= v1y; v2x_r <= v2x; v2y_r <= v2y;
         end
         // Empty boxes report completion one cycle later, from IDLE.
         empty_done_q <= (state_q == SETUP) && box_empty;
         if ((state_q == SETUP) && !box_empty) begin
            xmin_r <= bx_lo[15] ? '0 : bx_lo[COORD_W-1:0];
            xmax_r <= (bx_hi > X_LAST) ? COORD_W'(SCREEN_W - 1) : bx_hi[COORD_W-1:0];
            ymax_r <= (by_hi > Y_LAST) ? COORD_W'(SCREEN_H - 1) : by_hi[COORD_W-1:0];
            x_q    <= bx_lo[15] ? '0 : {1'b0, bx_lo[COORD_W-1:0]};
            y_q    <= by_lo[15] ? '0 : {1'b0, by_lo[COORD_W-1:0]};
         end
         if (adv) begin
            if (x_q == {1'b0, xmax_r}) begin
               x_q <= {1'b0, xmin_r};
               y_q <= y_q + ONE;
            end else begin
               x_q <= x_q + ONE;
            end
            frag_valid <= ef_inside;
            if (ef_inside) begin
               frag_x <= x_q[COORD_W-1:0];
               frag_y <= y_q[COORD_W-1:0];
            end
         end else if (frag_valid && frag_ready) begin
            frag_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_tri_bbox_scanner.sv
// Directed bench for tri_bbox_scanner: behavioural edge test, fragment scoreboard, latency and reset checks.
module tb_tri_bbox_scanner;

   localparam int COORD_W = 10;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               tri_valid, tri_ready;
   logic [15:0]        v0x, v0y, v1x, v1y, v2x, v2y;
   logic [15:0]        ef_v0x, ef_v0y, ef_v1x, ef_v1y, ef_v2x, ef_v2y, ef_px, ef_py;
   logic               ef_inside;
   logic               frag_valid, frag_ready;
   logic [COORD_W-1:0] frag_x, frag_y;
   logic               tri_done;
   logic [1:0]         state_dbg;

   int checks   = 0;
   int errors   = 0;
   int frag_cnt = 0;
   logic [2*COORD_W-1:0] exp_q[$];

   tri_bbox_scanner dut (
      .clk(clk), .rst_n(rst_n), .tri_valid(tri_valid), .tri_ready(tri_ready),
      .v0x(v0x), .v0y(v0y), .v1x(v1x), .v1y(v1y), .v2x(v2x), .v2y(v2y),
      .ef_v0x(ef_v0x), .ef_v0y(ef_v0y), .ef_v1x(ef_v1x), .ef_v1y(ef_v1y),
      .ef_v2x(ef_v2x), .ef_v2y(ef_v2y), .ef_px(ef_px), .ef_py(ef_py),
      .ef_inside(ef_inside), .frag_valid(frag_valid), .frag_ready(frag_ready),
      .frag_x(frag_x), .frag_y(frag_y), .tri_done(tri_done), .state_dbg(state_dbg)
   );

   // Clock and watchdog
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Downstream edge test: inside when all three edge functions are non-negative
   function automatic longint edge_fn(input logic [15:0] ax, ay, bx, by, px, py);
      longint sax, say, sbx, sby, spx, spy;
      sax = longint'($signed(ax)); say = longint'($signed(ay));
      sbx = longint'($signed(bx)); sby = longint'($signed(by));
      spx = longint'($signed(px)); spy = longint'($signed(py));
      return (spx - sax) * (sby - say) - (spy - say) * (sbx - sax);
   endfunction

   always_comb begin
      ef_inside = (edge_fn(ef_v0x, ef_v0y, ef_v1x, ef_v1y, ef_px, ef_py) >= 0) &&
                  (edge_fn(ef_v1x, ef_v1y, ef_v2x, ef_v2y, ef_px, ef_py) >= 0) &&
                  (edge_fn(ef_v2x, ef_v2y, ef_v0x, ef_v0y, ef_px, ef_py) >= 0);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   // Scoreboard: a transfer is committed when valid && ready at the negedge before the active edge
   always @(negedge clk) begin
      if (rst_n && frag_valid && frag_ready) begin
         frag_cnt++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL frag_extra: observed (%0d,%0d) expected no fragment", frag_x, frag_y);
         end else begin
            logic [2*COORD_W-1:0] exp;
            exp = exp_q.pop_front();
            check("frag_xy", 32'({frag_x, frag_y}), 32'(exp));
         end
      end
   end

   task automatic push_frag(input int x, input int y);
      exp_q.push_back({COORD_W'(x), COORD_W'(y)});
   endtask

   task automatic push_basic();
      for (int y = 0; y < 4; y++)
         for (int x = 0; x < 4 - y; x++)
            push_frag(x, y);
   endtask

   // Driver
   task automatic drive_tri(input logic [15:0] ax, ay, bx, by, cx, cy);
      int w;
      w = 0;
      @(negedge clk);
      v0x = ax; v0y = ay; v1x = bx; v1y = by; v2x = cx; v2y = cy;
      tri_valid = 1'b1;
      while (!tri_ready && w < 100) begin
         @(negedge clk);
         w++;
      end
      check("handshake_ready", 32'(tri_ready), 32'd1);
      @(posedge clk);
      #1 tri_valid = 1'b0;
   endtask

   task automatic wait_done(input int exp_cycles, input string tag);
      int cnt;
      bit seen;
      cnt  = 0;
      seen = 1'b0;
      while (!seen && cnt < 3000) begin
         @(negedge clk);
         cnt++;
         if (cnt == 1) check({tag, "_setup_ready"}, 32'(tri_ready), 32'd0);
         if (cnt == 2 && exp_cycles > 2) begin
            check({tag, "_first_px"}, 32'(ef_px), 32'd8);
            check({tag, "_first_py"}, 32'(ef_py), 32'd8);
         end
         if (tri_done) seen = 1'b1;
      end
      check({tag, "_done_seen"}, 32'(seen), 32'd1);
      if (exp_cycles > 0) check({tag, "_done_cycle"}, 32'(cnt), 32'(exp_cycles));
      @(negedge clk);
      check({tag, "_done_pulse"}, 32'(tri_done), 32'd0);
      check({tag, "_ready_after"}, 32'(tri_ready), 32'd1);
   endtask

   task automatic finish_tri(input int exp_frags, input string tag);
      repeat (3) @(negedge clk);
      check({tag, "_frag_count"}, 32'(frag_cnt), 32'(exp_frags));
      check({tag, "_queue_left"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      int w;
      int wind_frags;
      rst_n = 1'b0; tri_valid = 1'b0; frag_ready = 1'b1;
      v0x = '0; v0y = '0; v1x = '0; v1y = '0; v2x = '0; v2y = '0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_tri_ready", 32'(tri_ready), 32'd0);
      check("rst_frag_valid", 32'(frag_valid), 32'd0);
      check("rst_frag_x", 32'(frag_x), 32'd0);
      check("rst_frag_y", 32'(frag_y), 32'd0);
      check("rst_tri_done", 32'(tri_done), 32'd0);
      check("rst_ef_px", 32'(ef_px), 32'd0);
      check("rst_ef_v1x", 32'(ef_v1x), 32'd0);
      check("rst_state", 32'(state_dbg), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_ready", 32'(tri_ready), 32'd1);

      // Basic right triangle: 5x5 box, 10 fragments
      frag_cnt = 0;
      push_basic();
      drive_tri(16'd0, 16'd0, 16'd0, 16'd64, 16'd64, 16'd0);
      wait_done(26, "basic");
      finish_tri(10, "basic");

      // Opposite winding
      frag_cnt = 0;
`ifdef RASTER_WINDING_FIX_EN
      push_basic();
      wind_frags = 10;
`else
      wind_frags = 0;
`endif
      drive_tri(16'd0, 16'd0, 16'd64, 16'd0, 16'd0, 16'd64);
      wait_done(26, "winding");
      finish_tri(wind_frags, "winding");

      // Backpressure: hold the first fragment for 5 cycles
      frag_cnt = 0;
      push_basic();
      frag_ready = 1'b0;
      fork
         begin
            drive_tri(16'd0, 16'd0, 16'd0, 16'd64, 16'd64, 16'd0);
            wait_done(0, "bp");
         end
         begin
            w = 0;
            while (!frag_valid && w < 60) begin
               @(negedge clk);
               w++;
            end
            for (int i = 0; i < 5; i++) begin
               check("bp_hold_valid", 32'(frag_valid), 32'd1);
               check("bp_hold_xy", 32'({frag_x, frag_y}), 32'd0);
               @(negedge clk);
            end
            @(posedge clk);
            #1 frag_ready = 1'b1;
         end
      join
      finish_tri(10, "bp");

      // Clipped box: 16 pixels scanned, only (0,0) inside
      frag_cnt = 0;
      push_frag(0, 0);
      drive_tri(-16'sd32, -16'sd32, -16'sd32, 16'd48, 16'd48, -16'sd32);
      wait_done(17, "clip");
      finish_tri(1, "clip");

      // Entirely left of the screen
      frag_cnt = 0;
      drive_tri(-16'sd64, 16'd0, -16'sd64, 16'd64, -16'sd16, 16'd0);
      wait_done(2, "offscreen");
      finish_tri(0, "offscreen");

      // Reset in the middle of traversal
      frag_cnt = 0;
      push_basic();
      drive_tri(16'd0, 16'd0, 16'd0, 16'd64, 16'd64, 16'd0);
      w = 0;
      while (frag_cnt < 3 && w < 100) begin
         @(negedge clk);
         #1;
         w++;
      end
      check("rst_mid_frags", 32'(frag_cnt), 32'd3);
      @(posedge clk);
      #1;
      check("rst_mid_pending", 32'(frag_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rst_mid_valid", 32'(frag_valid), 32'd0);
      check("rst_mid_state", 32'(state_dbg), 32'd0);
      check("rst_mid_done", 32'(tri_done), 32'd0);
      check("rst_mid_ready", 32'(tri_ready), 32'd0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      frag_cnt = 0;
      push_basic();
      drive_tri(16'd0, 16'd0, 16'd0, 16'd64, 16'd64, 16'd0);
      wait_done(26, "after_rst");
      finish_tri(10, "after_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
